// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: 2-FF synchroniser, 3-sample majority vote,
// configurable data width / parity / stop bits, parity, framing and break flags.
module uart_rx_frame #(
   parameter int c_CYCLES_PER_BIT = 434,
   parameter int c_DATA_BITS      = 8,
   parameter int c_PARITY         = 0,
   parameter int c_STOP_BITS      = 1
) (
   input  logic                   i_CLK,
   input  logic                   i_RESET_n,
   input  logic                   i_SERIAL_DATA,
   output logic [c_DATA_BITS-1:0] o_DATA_RX,
   output logic                   o_RX_DATA_VALID,
   output logic                   o_PARITY_ERR,
   output logic                   o_FRAME_ERR,
   output logic                   o_BREAK,
   output logic                   o_BUSY
);

   localparam int            CW    = $clog2(c_CYCLES_PER_BIT);
   localparam int            BW    = 4;
   localparam logic [CW-1:0] HALF  = CW'(c_CYCLES_PER_BIT / 2);
   localparam logic [CW-1:0] LAST  = CW'(c_CYCLES_PER_BIT - 1);
   localparam logic [BW-1:0] DLAST = BW'(c_DATA_BITS - 1);
   localparam logic [BW-1:0] SLAST = BW'(c_STOP_BITS - 1);
   localparam logic          ODD   = (c_PARITY == 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic                   sync1_q, sync1_d, sync2_q, sync2_d;
   logic [2:0]             samp_q, samp_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [c_DATA_BITS-1:0] shreg_q, shreg_d;
   logic [c_DATA_BITS-1:0] dout_q, dout_d;
   logic                   par_err_q, par_err_d;
   logic                   frm_err_q, frm_err_d;
   logic                   armed_q, armed_d;
   logic                   vote, tick, half;

   assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
   assign tick = (cnt_q == LAST);
   assign half = (cnt_q == HALF);

   // Input path: two-stage synchroniser feeding the 3-deep vote window
   always_comb begin
      sync1_d = i_SERIAL_DATA;
      sync2_d = sync1_q;
      samp_d  = {samp_q[1:0], sync2_q};
   end

   // State and datapath registers; line-side flops reset to idle-high
   always_ff @(posedge i_CLK or negedge i_RESET_n) begin
      if (!i_RESET_n) begin
         state_q   <= S_IDLE;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         samp_q    <= 3'b111;
         cnt_q     <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         dout_q    <= '0;
         par_err_q <= 1'b0;
         frm_err_q <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         samp_q    <= samp_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         dout_q    <= dout_d;
         par_err_q <= par_err_d;
         frm_err_q <= frm_err_d;
         armed_q   <= armed_d;
      end
   end

   // Next-state: every sample after START lands one full bit period later
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (armed_q && !sync2_q) state_d = S_START;
         S_START:  if (half) state_d = vote ? S_IDLE : S_DATA;
         S_DATA:   if (tick && bit_q == DLAST) state_d = (c_PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (tick) state_d = S_STOP;
         S_STOP:   if (tick && bit_q == SLAST) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath: bit timing, LSB-first shift, error latching, output word load
   always_comb begin
      cnt_d     = cnt_q + 1'b1;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      dout_d    = dout_q;
      par_err_d = par_err_q;
      frm_err_d = frm_err_q;
      armed_d   = armed_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            // after a frame the line must be seen high once, so a held-low
            // break produces a single DONE rather than a stream of frames
            if (!armed_q) armed_d = sync2_q;
            else if (!sync2_q) begin
               par_err_d = 1'b0;
               frm_err_d = 1'b0;
            end
         end
         S_START: if (half && !vote) cnt_d = '0;
         S_DATA: if (tick) begin
            cnt_d   = '0;
            shreg_d = {vote, shreg_q[c_DATA_BITS-1:1]};
            bit_d   = (bit_q == DLAST) ? '0 : bit_q + 1'b1;
         end
         S_PARITY: if (tick) begin
            cnt_d     = '0;
            par_err_d = (^shreg_q) ^ vote ^ ODD;
         end
         S_STOP: if (tick) begin
            cnt_d = '0;
            bit_d = bit_q + 1'b1;
            if (!vote) frm_err_d = 1'b1;
            // load on the last stop sample so the word is stable during DONE
            if (bit_q == SLAST) dout_d = shreg_q;
         end
         S_DONE: armed_d = 1'b0;
         default: ;
      endcase
   end

   // Outputs: pulse and flags exist only in DONE
   always_comb begin
      o_RX_DATA_VALID = (state_q == S_DONE);
      o_PARITY_ERR    = o_RX_DATA_VALID & par_err_q;
      o_FRAME_ERR     = o_RX_DATA_VALID & frm_err_q;
      o_BREAK         = o_RX_DATA_VALID & frm_err_q & ~(|dout_q);
      o_BUSY          = (state_q != S_IDLE);
   end

   assign o_DATA_RX = dout_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: three instances (8N1, 8E1, 7N2) driven bit-serially,
// pulses captured into per-instance queues and compared with a frame-level model.
module tb_uart_rx_frame;

   localparam int CPB = 16;

   typedef struct packed {
      logic [8:0] d;
      logic       pe;
      logic       fe;
      logic       brk;
   } rec_t;

   typedef struct {
      int         s;
      logic [8:0] d;
      logic       pb;
      logic       sl;
      logic [8:0] ed;
      logic       epe, efe, ebrk;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_a, rx_p, rx_b;
   logic [7:0] dout_a, dout_p;
   logic [6:0] dout_b;
   logic       v_a, pe_a, fe_a, brk_a, busy_a;
   logic       v_p, pe_p, fe_p, brk_p, busy_p;
   logic       v_b, pe_b, fe_b, brk_b, busy_b;

   int   checks = 0;
   int   errors = 0;
   int   pulses[3];
   rec_t q0[$], q1[$], q2[$];
   rec_t mrec[3];
   logic [2:0] vld, flg, vld_prev;

   always #5 clk = ~clk;

   uart_rx_frame #(.c_CYCLES_PER_BIT(CPB), .c_DATA_BITS(8), .c_PARITY(0), .c_STOP_BITS(1)) u_dut_a (
      .i_CLK(clk), .i_RESET_n(rst_n), .i_SERIAL_DATA(rx_a), .o_DATA_RX(dout_a),
      .o_RX_DATA_VALID(v_a), .o_PARITY_ERR(pe_a), .o_FRAME_ERR(fe_a), .o_BREAK(brk_a), .o_BUSY(busy_a));
   uart_rx_frame #(.c_CYCLES_PER_BIT(CPB), .c_DATA_BITS(8), .c_PARITY(2), .c_STOP_BITS(1)) u_dut_p (
      .i_CLK(clk), .i_RESET_n(rst_n), .i_SERIAL_DATA(rx_p), .o_DATA_RX(dout_p),
      .o_RX_DATA_VALID(v_p), .o_PARITY_ERR(pe_p), .o_FRAME_ERR(fe_p), .o_BREAK(brk_p), .o_BUSY(busy_p));
   uart_rx_frame #(.c_CYCLES_PER_BIT(CPB), .c_DATA_BITS(7), .c_PARITY(0), .c_STOP_BITS(2)) u_dut_b (
      .i_CLK(clk), .i_RESET_n(rst_n), .i_SERIAL_DATA(rx_b), .o_DATA_RX(dout_b),
      .o_RX_DATA_VALID(v_b), .o_PARITY_ERR(pe_b), .o_FRAME_ERR(fe_b), .o_BREAK(brk_b), .o_BUSY(busy_b));

   assign mrec[0] = {1'b0, dout_a, pe_a, fe_a, brk_a};
   assign mrec[1] = {1'b0, dout_p, pe_p, fe_p, brk_p};
   assign mrec[2] = {2'b0, dout_b, pe_b, fe_b, brk_b};
   assign vld     = {v_b, v_p, v_a};
   assign flg     = {pe_b | fe_b | brk_b, pe_p | fe_p | brk_p, pe_a | fe_a | brk_a};

   initial begin
      vld_prev = '0;
      for (int k = 0; k < 3; k++) pulses[k] = 0;
   end

   // Monitor: capture every pulse, flag stretched pulses and unqualified flags
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 3; k++) begin
         if (vld[k]) begin
            pulses[k]++;
            if (vld_prev[k]) begin
               errors++;
               $display("FAIL pulse_width dut%0d: valid high 2 cycles, want 1", k);
            end
            case (k)
               0: q0.push_back(mrec[k]);
               1: q1.push_back(mrec[k]);
               default: q2.push_back(mrec[k]);
            endcase
         end else if (flg[k]) begin
            errors++;
            $display("FAIL flag_unqualified dut%0d: flag=1 with valid=0, want 0", k);
         end
      end
      vld_prev = vld;
   end

   function automatic int qsize(int s);
      case (s)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic rec_t qpop(int s);
      case (s)
         0: return q0.pop_front();
         1: return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   // Frame-level reference: what a correct receiver reports for a given frame
   function automatic rec_t model(int s, logic [8:0] d, logic pb, logic sl);
      rec_t r;
      logic [8:0] dm;
      dm    = (s == 2) ? (d & 9'h07F) : (d & 9'h0FF);
      r.d   = dm;
      r.pe  = (s == 1) ? ((^dm) ^ pb) : 1'b0;
      r.fe  = sl;
      r.brk = sl && (dm == 9'h0);
      return r;
   endfunction

   task automatic set_line(int s, logic v);
      case (s)
         0: rx_a = v;
         1: rx_p = v;
         default: rx_b = v;
      endcase
   endtask

   task automatic drive_bit(int s, logic v, bit gl);
      for (int i = 0; i < CPB; i++) begin
         set_line(s, (gl && i == CPB / 2) ? ~v : v);
         @(negedge clk);
      end
   endtask

   task automatic send_frame(int s, logic [8:0] d, logic pb, logic sl, bit gl);
      int nb, ns;
      nb = (s == 2) ? 7 : 8;
      ns = (s == 2) ? 2 : 1;
      drive_bit(s, 1'b0, 1'b0);
      for (int i = 0; i < nb; i++) drive_bit(s, d[i], gl);
      if (s == 1) drive_bit(s, pb, 1'b0);
      for (int j = 0; j < ns; j++) drive_bit(s, !(j == 0 && sl), 1'b0);
      set_line(s, 1'b1);
   endtask

   task automatic idle(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_rec(int s, rec_t exp, string name);
      int   n;
      rec_t got;
      n = 0;
      while (qsize(s) == 0 && n < 4 * CPB) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (qsize(s) == 0) begin
         errors++;
         $display("FAIL %s: no valid pulse within %0d cycles", name, 4 * CPB);
      end else begin
         got = qpop(s);
         if (got !== exp) begin
            errors++;
            $display("FAIL %s: got d=%h pe=%b fe=%b brk=%b, want d=%h pe=%b fe=%b brk=%b",
                     name, got.d, got.pe, got.fe, got.brk, exp.d, exp.pe, exp.fe, exp.brk);
         end
      end
   endtask

   task automatic check_val(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      vec_t tbl[8];
      rec_t exp;
      int   p0, s, gap;
      logic [8:0] d;
      logic pb, sl;

      tbl[0] = '{0, 9'h01A, 1'b0, 1'b0, 9'h01A, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1, 9'h035, 1'b1, 1'b0, 9'h035, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{1, 9'h035, 1'b0, 1'b0, 9'h035, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{0, 9'h0A5, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{1, 9'h081, 1'b0, 1'b0, 9'h081, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1, 9'h007, 1'b0, 1'b0, 9'h007, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{0, 9'h000, 1'b0, 1'b1, 9'h000, 1'b0, 1'b1, 1'b1};
      tbl[7] = '{1, 9'h000, 1'b1, 1'b1, 9'h000, 1'b1, 1'b1, 1'b1};

      rst_n = 1'b0;
      rx_a = 1'b1; rx_p = 1'b1; rx_b = 1'b1;
      idle(5);
      check_val("reset_a", {dout_a, v_a, pe_a, fe_a, brk_a, busy_a}, 0);
      check_val("reset_p", {dout_p, v_p, pe_p, fe_p, brk_p, busy_p}, 0);
      check_val("reset_b", {dout_b, v_b, pe_b, fe_b, brk_b, busy_b}, 0);
      rst_n = 1'b1;
      idle(CPB);

      // Directed frames from the vector table
      for (int i = 0; i < 8; i++) begin
         send_frame(tbl[i].s, tbl[i].d, tbl[i].pb, tbl[i].sl, 1'b0);
         expect_rec(tbl[i].s, {tbl[i].ed, tbl[i].epe, tbl[i].efe, tbl[i].ebrk}, $sformatf("table%0d", i));
         if (i == 0) check_val("busy_after_frame", busy_a, 0);
         idle(CPB);
      end

      // Break: line low for 12 bit times gives exactly one errored frame
      p0 = pulses[0];
      rx_a = 1'b0;
      idle(12 * CPB);
      rx_a = 1'b1;
      idle(2 * CPB);
      expect_rec(0, {9'h000, 1'b0, 1'b1, 1'b1}, "break");
      check_val("break_single_pulse", pulses[0] - p0, 1);

      // False start: short low pulse is rejected, next frame still received
      p0 = pulses[0];
      rx_a = 1'b0;
      idle(CPB / 2 - 4);
      rx_a = 1'b1;
      idle(3 * CPB);
      check_val("false_start_no_pulse", pulses[0] - p0, 0);
      check_val("false_start_idle", busy_a, 0);
      send_frame(0, 9'h03C, 1'b0, 1'b0, 1'b0);
      expect_rec(0, {9'h03C, 1'b0, 1'b0, 1'b0}, "after_false_start");
      idle(CPB);

      // Reset mid-frame after four data bits of 0xFF
      p0 = pulses[0];
      drive_bit(0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, 1'b0);
      check_val("busy_mid_frame", busy_a, 1);
      rst_n = 1'b0;
      idle(3);
      check_val("reset_mid_frame", {dout_a, v_a, pe_a, fe_a, brk_a, busy_a}, 0);
      rst_n = 1'b1;
      idle(3 * CPB);
      check_val("reset_no_pulse", pulses[0] - p0, 0);
      send_frame(0, 9'h05A, 1'b0, 1'b0, 1'b0);
      expect_rec(0, {9'h05A, 1'b0, 1'b0, 1'b0}, "after_reset");
      idle(CPB);

      // 7N2 back-to-back with single-cycle glitches at data bit centres
      send_frame(2, 9'h000, 1'b0, 1'b0, 1'b1);
      send_frame(2, 9'h07F, 1'b0, 1'b0, 1'b1);
      expect_rec(2, {9'h000, 1'b0, 1'b0, 1'b0}, "b2b_first");
      expect_rec(2, {9'h07F, 1'b0, 1'b0, 1'b0}, "b2b_second");
      idle(CPB);

      // Randomised frames on all three instances against the model
      for (int i = 0; i < 30; i++) begin
         s  = int'($urandom_range(0, 2));
         d  = 9'($urandom);
         pb = 1'($urandom);
         sl = ($urandom_range(0, 5) == 0);
         send_frame(s, d, pb, sl, 1'($urandom));
         exp = model(s, d, pb, sl);
         expect_rec(s, exp, $sformatf("rand%0d_dut%0d", i, s));
         gap = sl ? CPB : int'($urandom_range(0, CPB));
         idle(gap);
      end

      idle(2 * CPB);
      check_val("no_stray_pulses", q0.size() + q1.size() + q2.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
